// File: rtl/cpu4510_mapper_pkg.sv
// Shared constants and helpers for the 4510 MAP address translator.
//   kOP_EOM         : opcode that ends the MAP interrupt inhibit (NOP)
//   kMAP_BLOCK_BITS : log2 of the 8 KB mapping block size
//   kPHYS_AW        : physical bus address width
//   kEN_* / kOFS_*  : bit positions of the enable nibble and offset nibble within X/Z
package cpu4510_mapper_pkg;

   localparam logic [7:0]  kOP_EOM         = 8'hEA;
   localparam int unsigned kMAP_BLOCK_BITS = 13;
   localparam int unsigned kPHYS_AW        = 20;
   localparam int unsigned kLOG_AW         = 16;
   localparam int unsigned kOFS_W          = 12;
   localparam int unsigned kEN_W           = 4;

   // Positions within X (lo half) or Z (hi half)
   localparam int unsigned kEN_MSB  = 7;
   localparam int unsigned kEN_LSB  = 4;
   localparam int unsigned kOFS_MSB = 3;

   // Offset counts 256-byte pages; the sum wraps at 1 MB.
   function automatic logic [kPHYS_AW-1:0] map_xlate(input logic [kLOG_AW-1:0] addr,
                                                     input logic [kOFS_W-1:0]  ofs);
      logic [kPHYS_AW-1:0] base;
      logic [kPHYS_AW-1:0] disp;
      base = {4'h0, addr};
      disp = {ofs, 8'h00};
      return base + disp;
   endfunction

endpackage

// File: rtl/cpu4510_map_half.sv
// One half (four 8 KB blocks) of the 4510 MAP state.
//   clk, reset  : clock, asynchronous active-high reset
//   load_i      : load ofs_i/en_i this clock
//   ofs_i, en_i : new 12-bit page offset and per-block enables
//   addr_i      : logical address to translate (only bits [14:13] pick the block)
//   phys_o      : translated address (untouched when the block is disabled)
//   hit_o       : selected block is enabled
//   map_o       : monitor view {en, ofs}
module cpu4510_map_half
   import cpu4510_mapper_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic [kOFS_W-1:0]   ofs_i,
   input  logic [kEN_W-1:0]    en_i,
   input  logic [kLOG_AW-1:0]  addr_i,
   output logic [kPHYS_AW-1:0] phys_o,
   output logic                hit_o,
   output logic [15:0]         map_o
);

   logic [kOFS_W-1:0] ofs_d, ofs_q;
   logic [kEN_W-1:0]  en_d, en_q;
   logic [1:0]        blk;

   always_comb begin
      ofs_d = ofs_q;
      en_d  = en_q;
      if (load_i) begin
         ofs_d = ofs_i;
         en_d  = en_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ofs_q <= '0;
         en_q  <= '0;
      end else begin
         ofs_q <= ofs_d;
         en_q  <= en_d;
      end
   end

   // Block index within this half; bit 15 is the half select done by the caller
   assign blk    = addr_i[kMAP_BLOCK_BITS+1:kMAP_BLOCK_BITS];
   assign hit_o  = en_q[blk];
   assign phys_o = hit_o ? map_xlate(addr_i, ofs_q) : {4'h0, addr_i};
   assign map_o  = {en_q, ofs_q};

endmodule

// File: rtl/cpu4510_mapper.sv
// 4510 MAP address translator sitting after the 65CE02 core.
//   clk, reset, phi2        : clock, async active-high reset, phase enable
//   map                     : MAP strobe, loads lo/hi halves from A/X and Y/Z
//   reg_a/x/y/z             : core registers
//   sync, data_i            : opcode fetch indicator and opcode, for EOM detection
//   address_next            : core next logical address
//   phys_addr_next          : combinational translation of address_next
//   phys_addr, mapped       : registered translation, aligned with the core's address
//   irq_inhibit             : set by MAP, cleared after the next EOM fetch
//   map_lo, map_hi          : monitor view {enables, offset}
module cpu4510_mapper
   import cpu4510_mapper_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                phi2,
   input  logic                map,
   input  logic [7:0]          reg_a,
   input  logic [7:0]          reg_x,
   input  logic [7:0]          reg_y,
   input  logic [7:0]          reg_z,
   input  logic                sync,
   input  logic [7:0]          data_i,
   input  logic [kLOG_AW-1:0]  address_next,
   output logic [kPHYS_AW-1:0] phys_addr_next,
   output logic [kPHYS_AW-1:0] phys_addr,
   output logic                mapped,
   output logic                irq_inhibit,
   output logic [15:0]         map_lo,
   output logic [15:0]         map_hi
);

   logic                load;
   logic [kPHYS_AW-1:0] lo_phys, hi_phys;
   logic                lo_hit, hi_hit, hit_next;
   logic [kPHYS_AW-1:0] phys_d, phys_q;
   logic                mapped_d, mapped_q;
   logic                inhibit_d, inhibit_q;

   assign load = phi2 & map;

   cpu4510_map_half u_lo (
      .clk    (clk),
      .reset  (reset),
      .load_i (load),
      .ofs_i  ({reg_x[kOFS_MSB:0], reg_a}),
      .en_i   (reg_x[kEN_MSB:kEN_LSB]),
      .addr_i (address_next),
      .phys_o (lo_phys),
      .hit_o  (lo_hit),
      .map_o  (map_lo)
   );

   cpu4510_map_half u_hi (
      .clk    (clk),
      .reset  (reset),
      .load_i (load),
      .ofs_i  ({reg_z[kOFS_MSB:0], reg_y}),
      .en_i   (reg_z[kEN_MSB:kEN_LSB]),
      .addr_i (address_next),
      .phys_o (hi_phys),
      .hit_o  (hi_hit),
      .map_o  (map_hi)
   );

   assign phys_addr_next = address_next[15] ? hi_phys : lo_phys;
   assign hit_next       = address_next[15] ? hi_hit  : lo_hit;

   always_comb begin
      phys_d    = phys_q;
      mapped_d  = mapped_q;
      inhibit_d = inhibit_q;
      if (phi2) begin
         phys_d   = phys_addr_next;
         mapped_d = hit_next;
         // A MAP in the same cycle as an EOM fetch keeps the inhibit
         if (map) begin
            inhibit_d = 1'b1;
         end else if (sync && inhibit_q && (data_i == kOP_EOM)) begin
            inhibit_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phys_q    <= '0;
         mapped_q  <= 1'b0;
         inhibit_q <= 1'b0;
      end else begin
         phys_q    <= phys_d;
         mapped_q  <= mapped_d;
         inhibit_q <= inhibit_d;
      end
   end

   assign phys_addr   = phys_q;
   assign mapped      = mapped_q;
   assign irq_inhibit = inhibit_q;

endmodule

// File: tb/tb_cpu4510_mapper.sv
module tb_cpu4510_mapper;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        phi2 = 1'b0;
   logic        map = 1'b0;
   logic [7:0]  reg_a = '0, reg_x = '0, reg_y = '0, reg_z = '0;
   logic        sync = 1'b0;
   logic [7:0]  data_i = '0;
   logic [15:0] address_next = '0;
   logic [19:0] phys_addr_next, phys_addr;
   logic        mapped, irq_inhibit;
   logic [15:0] map_lo, map_hi;

   int checks = 0;
   int failures = 0;

   // Reference model state, kept as plain integers
   int m_ofs_lo, m_en_lo, m_ofs_hi, m_en_hi;
   int m_phys, m_mapped, m_inh;

   cpu4510_mapper dut (
      .clk            (clk),
      .reset          (reset),
      .phi2           (phi2),
      .map            (map),
      .reg_a          (reg_a),
      .reg_x          (reg_x),
      .reg_y          (reg_y),
      .reg_z          (reg_z),
      .sync           (sync),
      .data_i         (data_i),
      .address_next   (address_next),
      .phys_addr_next (phys_addr_next),
      .phys_addr      (phys_addr),
      .mapped         (mapped),
      .irq_inhibit    (irq_inhibit),
      .map_lo         (map_lo),
      .map_hi         (map_hi)
   );

   always #5 clk = ~clk;

   function automatic int model_hit(input int addr);
      int blk;
      blk = addr / 8192;
      if (blk < 4) return (m_en_lo >> blk) & 1;
      return (m_en_hi >> (blk - 4)) & 1;
   endfunction

   function automatic int model_phys(input int addr);
      int ofs;
      if (model_hit(addr) == 0) return addr;
      ofs = (addr >= 32768) ? m_ofs_hi : m_ofs_lo;
      return (addr + ofs * 256) % 1048576;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ofs_lo = 0; m_en_lo = 0; m_ofs_hi = 0; m_en_hi = 0;
      m_phys = 0; m_mapped = 0; m_inh = 0;
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, ".phys_addr"}, 32'(phys_addr), 32'(m_phys));
      chk({tag, ".mapped"}, 32'(mapped), 32'(m_mapped));
      chk({tag, ".irq_inhibit"}, 32'(irq_inhibit), 32'(m_inh));
      chk({tag, ".map_lo"}, 32'(map_lo), 32'(m_en_lo * 4096 + m_ofs_lo));
      chk({tag, ".map_hi"}, 32'(map_hi), 32'(m_en_hi * 4096 + m_ofs_hi));
   endtask

   // One bus cycle: drive inputs, check the combinational path, clock, check registers.
   task automatic cycle(input string tag, input logic ph, input logic mp, input logic sy,
                        input logic [7:0] d, input logic [7:0] a, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] z, input logic [15:0] addr);
      phi2 = ph; map = mp; sync = sy; data_i = d;
      reg_a = a; reg_x = x; reg_y = y; reg_z = z; address_next = addr;
      #1;
      chk({tag, ".phys_addr_next"}, 32'(phys_addr_next), 32'(model_phys(int'(addr))));
      @(posedge clk);
      if (ph) begin
         m_phys   = model_phys(int'(addr));
         m_mapped = model_hit(int'(addr));
         if (mp) begin
            m_ofs_lo = (int'(x) % 16) * 256 + int'(a);
            m_en_lo  = int'(x) / 16;
            m_ofs_hi = (int'(z) % 16) * 256 + int'(y);
            m_en_hi  = int'(z) / 16;
            m_inh    = 1;
         end else if (sy && m_inh == 1 && d == 8'hEA) begin
            m_inh = 0;
         end
      end
      #1;
      chk_regs(tag);
   endtask

   initial begin
      model_reset();
      // Power-on reset
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_regs("por");
      reset = 1'b0;

      // Lower half: X=$F1 enables blocks 0-3 with offset $100; load cycle uses the old map
      cycle("lo_load", 1, 1, 0, 8'h00, 8'h00, 8'hF1, 8'h00, 8'h00, 16'h2000);
      chk("lo_load.old_xlate", 32'(phys_addr), 32'h02000);
      chk("lo_load.inh_set", 32'(irq_inhibit), 32'h1);
      cycle("lo_2000", 1, 0, 0, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 16'h2000);
      chk("lo_2000.phys", 32'(phys_addr), 32'h12000);
      chk("lo_2000.mapped", 32'(mapped), 32'h1);
      cycle("lo_8000", 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h8000);
      chk("lo_8000.phys", 32'(phys_addr), 32'h08000);
      chk("lo_8000.mapped", 32'(mapped), 32'h0);

      // Inhibit: non-EOM opcode keeps it, EOM clears after its own fetch
      cycle("fetch_a9", 1, 0, 1, 8'hA9, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0100);
      chk("fetch_a9.inh", 32'(irq_inhibit), 32'h1);
      phi2 = 1; sync = 1; data_i = 8'hEA; address_next = 16'h0101; #1;
      chk("eom_fetch.inh_during", 32'(irq_inhibit), 32'h1);
      cycle("eom_fetch", 1, 0, 1, 8'hEA, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0101);
      chk("eom_fetch.inh_after", 32'(irq_inhibit), 32'h0);
      cycle("nop_idle", 1, 0, 1, 8'hEA, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0102);

      // Upper half with wrap, loaded on the same cycle as an EOM fetch
      cycle("hi_load_eom", 1, 1, 1, 8'hEA, 8'h00, 8'h00, 8'hFF, 8'h8F, 16'h0103);
      chk("hi_load_eom.inh", 32'(irq_inhibit), 32'h1);
      cycle("hi_e010", 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'hE010);
      chk("hi_e010.phys", 32'(phys_addr), 32'h0DF10);
      chk("hi_e010.mapped", 32'(mapped), 32'h1);
      cycle("hi_c000", 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'hC000);
      chk("hi_c000.phys", 32'(phys_addr), 32'h0C000);
      chk("hi_c000.mapped", 32'(mapped), 32'h0);

      // Phase hold: map strobe and address changes with phi2 low do nothing registered
      cycle("hold0", 0, 1, 1, 8'hEA, 8'h55, 8'hFF, 8'h66, 8'hFF, 16'h4000);
      cycle("hold1", 0, 1, 0, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 16'hE010);
      chk("hold.phys", 32'(phys_addr), 32'h0C000);
      chk("hold.map_hi", 32'(map_hi), 32'h8FFF);

      // Asynchronous reset mid-cycle with a map loaded
      reset = 1'b1;
      #1;
      model_reset();
      chk_regs("areset");
      address_next = 16'h1234;
      #1;
      chk("areset.phys_next", 32'(phys_addr_next), 32'h01234);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [7:0] d;
         d = ($urandom % 4 == 0) ? 8'hEA : 8'($urandom);
         cycle("rand", 1'($urandom % 4 != 0), 1'($urandom % 8 == 0), 1'($urandom % 3 == 0), d,
               8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu4510_mapper.md
# cpu4510_mapper

Downstream address-translation stage for the 65CE02 core: consumes the core's 16-bit `address_next` and `map` microcode strobe and produces the 20-bit physical bus address used by the memory system. It holds the 4510 MAP state: two 12-bit offsets, each with four 8 KB block enables. It also generates the interrupt inhibit that lasts from a MAP instruction until the following EOM (NOP) fetch. The block is phase-aligned with the core, so `phys_addr` changes on the same phi2 edge as the core's `address`.

## Interface
- No parameters.
- `clk`  in  1  system clock, same as core.
- `reset`  in  1  asynchronous, active-high.
- `phi2`  in  1  phase enable; all state updates occur on `posedge clk` with `phi2`=1.
- `map`  in  1  core MAP strobe; samples `reg_a`/`reg_x`/`reg_y`/`reg_z` when high with `phi2`.
- `reg_a`, `reg_x`, `reg_y`, `reg_z`  in  8 each  core architectural registers (monitor outputs).
- `sync`  in  1  core opcode-fetch cycle indicator.
- `data_i`  in  8  read data bus; holds the opcode during a sync cycle.
- `address_next`  in  16  core next logical address.
- `phys_addr_next`  out  20  combinational translated `address_next`.
- `phys_addr`  out  20  registered translation, updated on `phi2`; reset value 20'h00000.
- `mapped`  out  1  registered; 1 when the current `phys_addr` came from an enabled block; reset value 0.
- `irq_inhibit`  out  1  to interrupt control; reset value 0.
- `map_lo`, `map_hi`  out  16 each  monitor view, `{enables[3:0], offset[11:0]}`; reset value 0.

## Operation
- Logical space is split into eight 8 KB blocks: block = `address_next[15:13]`.
- Lower half covers blocks 0-3:
  - offset_lo[11:0] = {reg_x[3:0], reg_a}.
  - en_lo[3:0] = reg_x[7:4], bit n enables block n.
- Upper half covers blocks 4-7:
  - offset_hi[11:0] = {reg_z[3:0], reg_y}.
  - en_hi[3:0] = reg_z[7:4], bit n enables block n+4.
- Load: on `phi2 & map`, all four fields load at once, and `irq_inhibit` is set to 1.
- Translation when the block is enabled:
  - phys = ({4'h0, address_next} + {offset, 8'h00}) mod 2^20.
  - Carry out of bit 19 is discarded (wrap-around, e.g. offset 12'hFFF + $4000 -> 20'h03F00).
- Translation when the block is not enabled: phys = {4'h0, address_next}.
- EOM: on `phi2 & sync & irq_inhibit`, if `data_i` == 8'hEA, `irq_inhibit` clears.
  - Any other opcode leaves the inhibit set.
  - A NOP fetched while `irq_inhibit` is already 0 has no effect.
- Simultaneous `map` and EOM fetch in the same phi2 cycle: the load wins and `irq_inhibit` stays 1.
- `reset` asserted at any time asynchronously clears offsets, enables, `phys_addr`, `mapped` and `irq_inhibit`. No partial-map state survives.

## Timing
- `phys_addr_next` is a pure combinational function of `address_next` and the current map registers. There is no added latency versus the core's `address_next`.
- `phys_addr` / `mapped` register on `phi2`, tracking the core's `address` exactly: one phi2 cycle after `address_next`.
- A MAP load takes effect for `phys_addr_next` starting the cycle after the loading phi2 edge. The bus cycle during which `map` is high is translated with the old mapping.
- `irq_inhibit` rises the clock after the loading phi2 edge. It falls the clock after the EOM sync phi2 edge, so the EOM opcode's own fetch cycle is still inhibited.
- When `phi2`=0, all registers hold.

## Structure
- Shared package/include constants:
  - `kOP_EOM` = 8'hEA
  - `kMAP_BLOCK_BITS` = 13
  - `kPHYS_AW` = 20
  - field positions for enables and offset within X/Z.
- Sub-module `cpu4510_map_half` is instantiated twice (lo, hi). It holds one 12-bit offset and 4 enables, with a load port and a translate port (select bit `address_next[15]`).
- The top level adds the output mux, the `phys_addr`/`mapped` registers and the inhibit flag.

## Test plan
- Reset check: assert `reset` mid-run with a map loaded -> `phys_addr`=0, `mapped`=0, `irq_inhibit`=0, `map_lo`/`map_hi`=0; `address_next`=$1234 -> `phys_addr_next`=20'h01234.
- Lower-half map: load A=$00, X=$F1, Y=Z=0 -> `address_next`=$2000 gives 20'h12000 with `mapped`=1 one phi2 later; `address_next`=$8000 gives 20'h08000 with `mapped`=0.
- Upper-half map with wrap: load Y=$FF, Z=$8F -> `address_next`=$E010 gives 20'h0DF10 (wrapped); `address_next`=$C000 gives 20'h0C000 with `mapped`=0.
- Load timing: `map` high on a cycle with `address_next`=$2000 -> that cycle outputs the old translation; the next cycle outputs the new one.
- Inhibit sequence: map load, then sync fetches $A9 (inhibit stays 1), then $EA (clears the clock after that phi2); with `map` and sync/$EA in the same phi2 cycle -> inhibit stays 1.
- Phase hold: toggle `map` and `address_next` with `phi2`=0 -> no register or output change besides the combinational `phys_addr_next`.
